// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared types and helpers for the clock gate controller
package cv32e40p_pkg;
  typedef enum logic [1:0] {CC_RUN, CC_HOLDOFF, CC_SLEEP, CC_WAKE} clk_ctrl_state_e;
  // Width of the shared HOLDOFF/WAKE down-counter: wide enough for either load value, at least 1 bit.
  function automatic int unsigned cc_cnt_w(input int unsigned a, input int unsigned b);
    int unsigned w;
    w = ($clog2(a) > $clog2(b)) ? $clog2(a) : $clog2(b);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/cv32e40p_clock_gate_ctrl.sv
// cv32e40p_clock_gate_ctrl: sleep/wake FSM producing the registered core clock-gate enable
//   clk_i/rst_i              free-running clock, sync active-high reset
//   sleep_req_i, busy_i      sleep request level and activity that blocks gating
//   wake_i, wake_mask_i      wake event levels and per-source enables
//   debug_req_i              unmaskable wake
//   cnt_clr_i                clears sleep_cnt_o
//   en_o, sleeping_o, wake_o gate enable, gated/settling status, return-to-run pulse
//   sleep_cnt_o              saturating gated-cycle counter
module cv32e40p_clock_gate_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned IDLE_HOLDOFF = 4,
  parameter int unsigned WAKE_DELAY   = 2,
  parameter int unsigned N_WAKE       = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sleep_req_i,
  input  logic              busy_i,
  input  logic [N_WAKE-1:0] wake_i,
  input  logic [N_WAKE-1:0] wake_mask_i,
  input  logic              debug_req_i,
  input  logic              cnt_clr_i,
  output logic              en_o,
  output logic              sleeping_o,
  output logic              wake_o,
  output logic [31:0]       sleep_cnt_o
);
  localparam int unsigned CW = cc_cnt_w(IDLE_HOLDOFF, WAKE_DELAY);
  // Load values are one less than the window: the exit happens on the cycle the counter reads zero.
  localparam logic [CW-1:0] HO_LD = (IDLE_HOLDOFF == 0) ? '0 : CW'(IDLE_HOLDOFF - 1);
  localparam logic [CW-1:0] WK_LD = (WAKE_DELAY == 0) ? '0 : CW'(WAKE_DELAY - 1);
  clk_ctrl_state_e r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic            r_en, r_sleeping, r_wake;
  logic [31:0]     r_sleep_cnt;
  logic            w_wake_pend, w_idle_ok;
  assign w_wake_pend = (|(wake_i & wake_mask_i)) | debug_req_i;
  assign w_idle_ok   = sleep_req_i & ~busy_i & ~w_wake_pend;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      CC_RUN: begin
        if (w_idle_ok) begin
          w_state_nx = (IDLE_HOLDOFF == 0) ? CC_SLEEP : CC_HOLDOFF;
          w_cnt_nx   = HO_LD;
        end
      end
      CC_HOLDOFF: begin
        w_state_nx = !w_idle_ok ? CC_RUN : (r_cnt == '0) ? CC_SLEEP : CC_HOLDOFF;
        w_cnt_nx   = r_cnt - CW'(1);
      end
      CC_SLEEP: begin
        if (w_wake_pend) begin
          w_state_nx = (WAKE_DELAY == 0) ? CC_RUN : CC_WAKE;
          w_cnt_nx   = WK_LD;
        end
      end
      CC_WAKE: begin
        w_state_nx = (r_cnt == '0) ? CC_RUN : CC_WAKE;
        w_cnt_nx   = r_cnt - CW'(1);
      end
      default: begin
        w_state_nx = CC_RUN;
        w_cnt_nx   = '0;
      end
    endcase
  end
  // Outputs are registered from the next state so en_o only moves on a rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= CC_RUN;
      r_cnt       <= '0;
      r_en        <= 1'b1;
      r_sleeping  <= 1'b0;
      r_wake      <= 1'b0;
      r_sleep_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_en        <= (w_state_nx != CC_SLEEP);
      r_sleeping  <= (w_state_nx == CC_SLEEP) || (w_state_nx == CC_WAKE);
      r_wake      <= ((r_state == CC_SLEEP) || (r_state == CC_WAKE)) && (w_state_nx == CC_RUN);
      r_sleep_cnt <= cnt_clr_i ? '0 : ((r_state == CC_SLEEP) && !(&r_sleep_cnt)) ? r_sleep_cnt + 32'd1 : r_sleep_cnt;
    end
  end
  assign en_o        = r_en;
  assign sleeping_o  = r_sleeping;
  assign wake_o      = r_wake;
  assign sleep_cnt_o = r_sleep_cnt;
endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// tb_cv32e40p_clock_gate_ctrl: directed self-checking bench for the clock gate controller
module tb_cv32e40p_clock_gate_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sleep_req_i = 1'b0;
  logic        busy_i = 1'b0;
  logic [3:0]  wake_i = '0;
  logic [3:0]  wake_mask_i = '0;
  logic        debug_req_i = 1'b0;
  logic        cnt_clr_i = 1'b0;
  logic        en_o, sleeping_o, wake_o;
  logic [31:0] sleep_cnt_o;
  int n_tests = 0;
  int n_fail  = 0;
  cv32e40p_clock_gate_ctrl #(.IDLE_HOLDOFF(4), .WAKE_DELAY(2), .N_WAKE(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sleep_req_i(sleep_req_i), .busy_i(busy_i),
    .wake_i(wake_i), .wake_mask_i(wake_mask_i), .debug_req_i(debug_req_i),
    .cnt_clr_i(cnt_clr_i), .en_o(en_o), .sleeping_o(sleeping_o), .wake_o(wake_o),
    .sleep_cnt_o(sleep_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    step();
    step();
    rst_i = 1'b0;
    chk("rst_en", 32'(en_o), 32'd1);
    chk("rst_sleeping", 32'(sleeping_o), 32'd0);
    chk("rst_wake", 32'(wake_o), 32'd0);
    chk("rst_cnt", sleep_cnt_o, 32'd0);
    sleep_req_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("ho_en_hi", 32'(en_o), 32'd1);
    end
    step();
    chk("ho_en_lo", 32'(en_o), 32'd0);
    chk("ho_sleeping", 32'(sleeping_o), 32'd1);
    step();
    step();
    wake_i = 4'b0010;
    wake_mask_i = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("masked_no_wake", 32'(en_o), 32'd0);
    end
    wake_mask_i = 4'b0010;
    step();
    chk("wk_en_t1", 32'(en_o), 32'd1);
    chk("wk_sleeping_t1", 32'(sleeping_o), 32'd1);
    chk("wk_pulse_t1", 32'(wake_o), 32'd0);
    chk("cnt_10", sleep_cnt_o, 32'd10);
    wake_i = '0;
    wake_mask_i = '0;
    step();
    chk("wk_en_t2", 32'(en_o), 32'd1);
    chk("wk_sleeping_t2", 32'(sleeping_o), 32'd1);
    sleep_req_i = 1'b0;
    step();
    chk("wk_sleeping_t3", 32'(sleeping_o), 32'd0);
    chk("wk_pulse_t3", 32'(wake_o), 32'd1);
    chk("wk_en_t3", 32'(en_o), 32'd1);
    step();
    chk("wk_pulse_once", 32'(wake_o), 32'd0);
    sleep_req_i = 1'b1;
    step();
    step();
    busy_i = 1'b1;
    step();
    chk("abort_en", 32'(en_o), 32'd1);
    busy_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("abort_restart_hi", 32'(en_o), 32'd1);
    end
    step();
    chk("abort_restart_lo", 32'(en_o), 32'd0);
    chk("cnt_hold", sleep_cnt_o, 32'd10);
    cnt_clr_i = 1'b1;
    step();
    chk("cnt_clr_wins", sleep_cnt_o, 32'd0);
    cnt_clr_i = 1'b0;
    step();
    chk("cnt_after_clr", sleep_cnt_o, 32'd1);
    force dut.r_sleep_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_sleep_cnt;
    step();
    chk("cnt_sat_1", sleep_cnt_o, 32'hFFFF_FFFF);
    step();
    step();
    chk("cnt_sat_3", sleep_cnt_o, 32'hFFFF_FFFF);
    chk("still_gated", 32'(en_o), 32'd0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_sleep_en", 32'(en_o), 32'd1);
    chk("rst_sleep_sleeping", 32'(sleeping_o), 32'd0);
    chk("rst_sleep_cnt", sleep_cnt_o, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("dbg_pre_gated", 32'(en_o), 32'd0);
    debug_req_i = 1'b1;
    step();
    debug_req_i = 1'b0;
    chk("dbg_en_t1", 32'(en_o), 32'd1);
    step();
    chk("dbg_sleeping_t2", 32'(sleeping_o), 32'd1);
    step();
    chk("dbg_sleeping_t3", 32'(sleeping_o), 32'd0);
    chk("dbg_pulse_t3", 32'(wake_o), 32'd1);
    debug_req_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("dbg_vs_sleep_en", 32'(en_o), 32'd1);
    end
    debug_req_i = 1'b0;
    wake_i = 4'b1000;
    wake_mask_i = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("wake_vs_sleep_en", 32'(en_o), 32'd1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
